// File: rtl/arya_pipe_core.sv
// Five-stage load/store core (F, D, E, M, W) with a run/drain/halt mode machine,
// RAW-hazard stalling against in-flight loads, a retired counter and a debug memory port.
module arya_pipe_core #(
  parameter int DATA_W         = 64,
  parameter int MEM_ADDR_W     = 10,
  parameter int REG_ADDR_W     = 3,
  parameter int INST_MEM_START = 0,
  parameter int DATA_MEM_START = 512,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  setup_mem,
  input  logic                  verify_mem,
  input  logic [MEM_ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic                  running,
  output logic                  done,
  output logic [CNT_W-1:0]      retired
);
  localparam int MEM_WORDS = 1 << MEM_ADDR_W;
  localparam int NREGS     = 1 << REG_ADDR_W;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_e;

  state_e                  state_q;
  logic                    running_q, done_q;
  logic [CNT_W-1:0]        retired_q;
  logic [DATA_W-1:0]       mem_data_out_q;
  logic [MEM_ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]       mem [MEM_WORDS];
  logic [DATA_W-1:0]       regs_q [NREGS];

  logic                    vld_p0_q;
  logic [31:0]             inst_p0_q;
  logic                    vld_p1_q, ld_p1_q, st_p1_q;
  logic [REG_ADDR_W-1:0]   rd_p1_q;
  logic [DATA_W-1:0]       rs1v_p1_q, rs2v_p1_q;
  logic signed [DATA_W-1:0] imm_p1_q;
  logic                    vld_p2_q, ld_p2_q, st_p2_q;
  logic [REG_ADDR_W-1:0]   rd_p2_q;
  logic [MEM_ADDR_W-1:0]   ea_p2_q;
  logic [DATA_W-1:0]       data_p2_q;
  logic                    vld_p3_q, ld_p3_q;
  logic [REG_ADDR_W-1:0]   rd_p3_q;
  logic [DATA_W-1:0]       ldata_p3_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Decode stage: field extraction, register read with WB bypass, hazard detect
  logic [3:0]               op_d;
  logic [REG_ADDR_W-1:0]    rd_d, rs1_d, rs2_d;
  logic                     is_ld_d, is_st_d, is_halt_d, wb_en, hit1_d, hit2_d, stall_d;
  logic                     fetch_en, debug_en;
  logic [DATA_W-1:0]        rs1v_d, rs2v_d;
  logic signed [DATA_W-1:0] imm_d;
  logic [MEM_ADDR_W-1:0]    ea_e;

  assign op_d      = inst_p0_q[31:28];
  assign rd_d      = REG_ADDR_W'(inst_p0_q[27:24]);
  assign rs1_d     = REG_ADDR_W'(inst_p0_q[23:20]);
  assign rs2_d     = REG_ADDR_W'(inst_p0_q[19:16]);
  assign imm_d     = {{(DATA_W-16){inst_p0_q[15]}}, inst_p0_q[15:0]};
  assign is_ld_d   = vld_p0_q && (op_d == OP_LOAD);
  assign is_st_d   = vld_p0_q && (op_d == OP_STORE);
  assign is_halt_d = vld_p0_q && (op_d == OP_HALT);
  assign wb_en     = vld_p3_q && ld_p3_q;
  assign rs1v_d    = (wb_en && rd_p3_q == rs1_d) ? ldata_p3_q : regs_q[rs1_d];
  assign rs2v_d    = (wb_en && rd_p3_q == rs2_d) ? ldata_p3_q : regs_q[rs2_d];
  assign hit1_d    = (vld_p1_q && ld_p1_q && rd_p1_q == rs1_d) ||
                     (vld_p2_q && ld_p2_q && rd_p2_q == rs1_d);
  assign hit2_d    = (vld_p1_q && ld_p1_q && rd_p1_q == rs2_d) ||
                     (vld_p2_q && ld_p2_q && rd_p2_q == rs2_d);
  assign stall_d   = ((is_ld_d || is_st_d) && hit1_d) || (is_st_d && hit2_d);
  assign fetch_en  = (state_q == S_RUN) && !stall_d && !is_halt_d;
  assign debug_en  = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign ea_e      = MEM_ADDR_W'(rs1v_p1_q + $unsigned(imm_p1_q) + DATA_W'(DATA_MEM_START));

  // Control: mode machine, PC, stage valids, register file write and retire count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
      retired_q      <= '0;
      mem_data_out_q <= '0;
      pc_q           <= MEM_ADDR_W'(INST_MEM_START);
      {vld_p0_q, vld_p1_q, ld_p1_q, st_p1_q} <= '0;
      {vld_p2_q, ld_p2_q, st_p2_q, vld_p3_q, ld_p3_q} <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (verify_mem) mem_data_out_q <= mem[mem_addr_in];
          if (start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            retired_q <= '0;
            pc_q      <= MEM_ADDR_W'(INST_MEM_START);
            {vld_p0_q, vld_p1_q, ld_p1_q, st_p1_q} <= '0;
            {vld_p2_q, ld_p2_q, st_p2_q, vld_p3_q, ld_p3_q} <= '0;
          end
        end
        S_RUN, S_DRAIN: begin
          if (fetch_en) begin
            vld_p0_q <= 1'b1;
            pc_q     <= pc_q + MEM_ADDR_W'(1);
          end else if (!stall_d) begin
            vld_p0_q <= 1'b0;
          end
          vld_p1_q <= vld_p0_q && !stall_d && !is_halt_d;
          ld_p1_q  <= is_ld_d && !stall_d;
          st_p1_q  <= is_st_d && !stall_d;
          vld_p2_q <= vld_p1_q;
          ld_p2_q  <= ld_p1_q;
          st_p2_q  <= st_p1_q;
          vld_p3_q <= vld_p2_q;
          ld_p3_q  <= ld_p2_q;
          if (wb_en) regs_q[rd_p3_q] <= ldata_p3_q;
          if (vld_p3_q) retired_q <= sat_inc(retired_q);
          if (state_q == S_RUN && is_halt_d) begin
            state_q <= S_DRAIN;
          end else if (state_q == S_DRAIN && !vld_p1_q && !vld_p2_q && !vld_p3_q) begin
            state_q   <= S_HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath: instruction fetch, D/E and E/M payloads, memory ports A and B
  always_ff @(posedge clk) begin
    if (fetch_en) inst_p0_q <= mem[pc_q][31:0];
    rd_p1_q   <= rd_d;
    rs1v_p1_q <= rs1v_d;
    rs2v_p1_q <= rs2v_d;
    imm_p1_q  <= imm_d;
    rd_p2_q   <= rd_p1_q;
    ea_p2_q   <= ea_e;
    data_p2_q <= rs2v_p1_q;
    rd_p3_q   <= rd_p2_q;
    if (vld_p2_q && ld_p2_q) ldata_p3_q <= mem[ea_p2_q];
    if (vld_p2_q && st_p2_q) mem[ea_p2_q] <= data_p2_q;
    if (debug_en && setup_mem) mem[mem_addr_in] <= mem_data_in;
  end

  assign mem_data_out = mem_data_out_q;
  assign running      = running_q;
  assign done         = done_q;
  assign retired      = retired_q;
endmodule

// File: tb/tb_arya_pipe_core.sv
// Randomized and directed bench for arya_pipe_core against an instruction-level
// reference model that also predicts issue timing from the load-use stall rule.
module tb_arya_pipe_core;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, start, setup_mem, verify_mem;
  logic [AW-1:0] mem_addr_in;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          running, done;
  logic [CW-1:0] retired;

  int total = 0;
  int bad   = 0;

  arya_pipe_core dut (
    .clk(clk), .reset(reset), .start(start), .setup_mem(setup_mem),
    .verify_mem(verify_mem), .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .running(running), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mmem  [1024];
  logic [DW-1:0] mregs [8];
  logic [31:0]   prog [$];
  int            st_addrs [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  function automatic int ea_of(input logic [63:0] base, input logic [15:0] imm);
    logic [63:0] s;
    s = 64'd512 + base + {{48{imm[15]}}, imm};
    return int'(s % 64'd1024);
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    setup_mem = 1'b1; mem_addr_in = a; mem_data_in = d;
    @(posedge clk); #1;
    setup_mem = 1'b0;
    mmem[a] = d;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    verify_mem = 1'b1; mem_addr_in = a;
    @(posedge clk); #1;
    verify_mem = 1'b0;
    d = mem_data_out;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    foreach (mregs[k]) mregs[k] = '0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) wr(AW'(i), {32'h0, prog[i]});
  endtask

  // Sequential ISA execution; instruction i leaves Decode at cycle d_i, a
  // dependent source must wait until its producing load is 3 cycles past Decode.
  task automatic model_run(output int exp_ret, output int exp_cyc);
    int ld_d [8];
    int dprev, di, op, rdx, r1, r2, ea;
    logic [31:0] w;
    st_addrs.delete();
    exp_ret = 0; exp_cyc = -1; dprev = 0;
    foreach (ld_d[k]) ld_d[k] = -100;
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      op = int'(w[31:28]); rdx = int'(w[26:24]); r1 = int'(w[22:20]); r2 = int'(w[18:16]);
      di = dprev + 1;
      if (op == 15) begin
        exp_cyc = di + 4;
        break;
      end
      if ((op == 1 || op == 2) && ld_d[r1] + 3 > di) di = ld_d[r1] + 3;
      if (op == 2 && ld_d[r2] + 3 > di) di = ld_d[r2] + 3;
      ea = ea_of(mregs[r1], w[15:0]);
      if (op == 1) begin
        mregs[rdx] = mmem[ea];
        ld_d[rdx]  = di;
      end
      if (op == 2) begin
        mmem[ea] = mregs[r2];
        st_addrs.push_back(ea);
      end
      exp_ret++;
      dprev = di;
    end
  endtask

  task automatic run_check(input string tag, input bit poke, output int cyc, output int nret);
    int exp_ret, exp_cyc;
    logic [DW-1:0] prev, got;
    model_run(exp_ret, exp_cyc);
    prev = mem_data_out;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_running"}, 64'(running), 64'd1);
    if (poke) begin
      verify_mem = 1'b1; setup_mem = 1'b1; mem_addr_in = AW'(700); mem_data_in = ~mmem[700];
    end
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin verify_mem = 1'b0; setup_mem = 1'b0; end
    end
    nret = int'(retired);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_retired"}, 64'(retired), 64'(exp_ret));
    chk({tag, "_running_off"}, 64'(running), 64'd0);
    if (poke) begin
      chk({tag, "_dout_hold_in_run"}, mem_data_out, prev);
      rd(AW'(700), got);
      chk({tag, "_setup_ignored_in_run"}, got, mmem[700]);
    end
    foreach (st_addrs[k]) begin
      rd(AW'(st_addrs[k]), got);
      chk({tag, "_store"}, got, mmem[st_addrs[k]]);
    end
  endtask

  initial begin
    logic [DW-1:0] got, v, w511;
    int cyc, nret, n, pick;
    reset = 1'b0; start = 1'b0; setup_mem = 1'b0; verify_mem = 1'b0;
    mem_addr_in = '0; mem_data_in = '0;
    foreach (mregs[k]) mregs[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_dout", mem_data_out, 64'd0);
    @(negedge clk); reset = 1'b1;

    wr(AW'(600), 64'hDEADBEEF_01234567);
    rd(AW'(600), got);
    chk("dbg_roundtrip", got, 64'hDEADBEEF_01234567);
    @(negedge clk);
    setup_mem = 1'b1; verify_mem = 1'b1; mem_addr_in = AW'(600); mem_data_in = 64'h1111;
    @(posedge clk); #1;
    setup_mem = 1'b0; verify_mem = 1'b0; mmem[600] = 64'h1111;
    chk("dbg_both_old", mem_data_out, 64'hDEADBEEF_01234567);
    rd(AW'(600), got);
    chk("dbg_both_new", got, 64'h1111);

    // Data words keep their low address bits under 256 so computed EAs stay in 512..1022.
    for (int a = 511; a < 1024; a++) begin
      v = {$urandom, $urandom};
      v[9:0] = 10'($urandom_range(0, 255));
      wr(AW'(a), v);
    end
    wr(AW'(512), 64'h55);

    prog = '{mk(1, 1, 0, 0, 0), mk(2, 0, 0, 1, 1), mk(15, 0, 0, 0, 0)};
    load_prog();
    run_check("ldst", 1'b1, cyc, nret);
    chk("ldst_two_stalls", 64'(cyc), 64'd9);
    chk("ldst_retired2", 64'(nret), 64'd2);
    rd(AW'(513), got);
    chk("ldst_mem513", got, 64'h55);
    run_check("restart", 1'b0, cyc, nret);
    chk("restart_cycles", 64'(cyc), 64'd9);
    chk("restart_retired", 64'(nret), 64'd2);

    pulse_reset();
    prog = '{mk(1, 1, 0, 0, 0), mk(1, 2, 0, 0, 1), mk(1, 3, 0, 0, 2), mk(1, 4, 0, 0, 3),
             mk(15, 0, 0, 0, 0)};
    load_prog();
    run_check("indep", 1'b0, cyc, nret);
    chk("indep_no_stall", 64'(cyc), 64'd9);
    chk("indep_retired4", 64'(nret), 64'd4);
    prog = '{mk(2, 0, 0, 1, 17), mk(2, 0, 0, 2, 18), mk(2, 0, 0, 3, 19), mk(2, 0, 0, 4, 20),
             mk(15, 0, 0, 0, 0)};
    load_prog();
    run_check("dump", 1'b0, cyc, nret);
    rd(AW'(532), got);
    chk("dump_r4", got, mmem[515]);

    w511 = mmem[511];
    prog = '{mk(1, 2, 0, 0, 16'h7FFF), mk(1, 3, 0, 0, 16'hFFFF), mk(2, 0, 0, 2, 10),
             mk(2, 0, 0, 3, 11), mk(15, 0, 0, 0, 0)};
    load_prog();
    run_check("wrap", 1'b0, cyc, nret);
    rd(AW'(522), got);
    chk("wrap_pos", got, w511);
    rd(AW'(523), got);
    chk("wrap_neg", got, w511);

    for (int t = 0; t < 6; t++) begin
      prog.delete();
      n = $urandom_range(5, 12);
      for (int i = 0; i < n; i++) begin
        pick = $urandom_range(0, 5);
        prog.push_back(mk((pick == 0) ? 0 : (pick <= 2) ? 1 : (pick <= 4) ? 2 : 9,
                          $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 15), $urandom_range(0, 255)));
      end
      prog.push_back(mk(15, 0, 0, 0, 0));
      load_prog();
      run_check("rand", 1'b0, cyc, nret);
    end

    pulse_reset();
    prog = '{mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(1, 1, 0, 0, 0),
             mk(2, 0, 0, 1, 5), mk(15, 0, 0, 0, 0)};
    load_prog();
    wr(AW'(517), 64'hCAFE_F00D);
    rd(AW'(517), got);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_pre_retired", 64'(retired), 64'd1);
    chk("abort_pre_running", 64'(running), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_running", 64'(running), 64'd0);
    chk("abort_retired", 64'(retired), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_dout", mem_data_out, 64'd0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle_running", 64'(running), 64'd0);
    rd(AW'(517), got);
    chk("abort_no_store", got, 64'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arya_pipe_core.md
Name: arya_pipe_core

Overview:
- Parametrised successor of the single-configuration five-stage core: Fetch, Decode, Execute, Mem, Writeback.
- Adds a mode state machine (setup/verify/run/drain/halt), a HALT instruction and RAW-hazard stalling.
- Adds a retired-instruction counter and a generic datapath, register-file and memory width.
- Owns the unified dual-port memory and the register file internally; the testbench/SoC loads programs and checks data through the debug port.

Parameters:
- DATA_W, 64, datapath, register and memory word width.
- MEM_ADDR_W, 10, unified memory address width (2**MEM_ADDR_W words).
- REG_ADDR_W, 3, register address width (1..4).
- INST_MEM_START, 0, PC value after reset/start.
- DATA_MEM_START, 512, base added to every load/store effective address.
- CNT_W, 32, retired counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse: begin execution from IDLE or HALTED.
- setup_mem  in  1  debug write: mem[mem_addr_in] <= mem_data_in.
- verify_mem  in  1  debug read of mem[mem_addr_in].
- mem_addr_in  in  MEM_ADDR_W  debug address.
- mem_data_in  in  DATA_W  debug write data.
- mem_data_out  out  DATA_W  debug read data.
- running  out  1  high in RUN and DRAIN.
- done  out  1  high in HALTED.
- retired  out  CNT_W  count of retired LOAD/STORE/NOP instructions since last start.

Behaviour:
- Reset (reset=0, async): FSM=IDLE; PC=INST_MEM_START; all pipeline registers cleared to bubbles (write enables 0); registers all 0; retired=0; mem_data_out=0; running=0; done=0. Memory contents are not reset.
- Instruction format (low 32 bits of a memory word):
  - op [31:28]: 0 NOP, 1 LOAD, 2 STORE, 15 HALT; any other value executes as NOP.
  - rd [27:24], rs1 [23:20], rs2 [19:16]; only the low REG_ADDR_W bits are used.
  - imm [15:0], sign-extended to DATA_W.
- LOAD: rd <= mem[EA]. STORE: mem[EA] <= rs2.
  - EA = (DATA_MEM_START + rs1 + imm), truncated to MEM_ADDR_W; wrap-around is silent.
  - Register 0 is an ordinary writable register.
- Memory: port A serves fetch and debug; port B serves load/store. Both ports are synchronous-read with 1-cycle latency.
- FSM states:
  - IDLE: setup_mem/verify_mem serviced; start -> RUN.
  - RUN: fetch every cycle unless stalled; HALT decoded -> DRAIN.
  - DRAIN: fetch stops; instructions older than HALT complete; when E, M and W are all bubbles -> HALTED.
  - HALTED: debug port serviced; start -> RUN.
- Entering RUN: PC=INST_MEM_START, retired=0, pipeline flushed.
- Debug port (IDLE/HALTED only):
  - setup_mem writes port A.
  - verify_mem updates mem_data_out one cycle later; otherwise mem_data_out holds its value.
  - If both are high, the write happens and mem_data_out shows the old data.
  - Both inputs are ignored in RUN/DRAIN.
- Fetch: PC addresses port A; the instruction enters F/D one cycle later; PC increments by 1 and wraps at 2**MEM_ADDR_W.
- Register file: 2 read ports, 1 write port. Write-before-read bypass: a WB write to the register being read in the same cycle returns the new data.
- Hazard rule: stall when the Decode instruction reads rs1 (LOAD/STORE) or rs2 (STORE) matching rd of a LOAD in Execute or Mem.
  - During a stall: PC and F/D hold (port A read enable deasserted so the output holds), and a bubble is inserted into D/E.
  - A dependent instruction directly after a LOAD therefore stalls exactly 2 cycles. No forwarding.
- Store-then-load to the same EA needs no stall: the store writes in Mem before the later load reads.
- retired increments when a non-bubble, non-HALT instruction leaves WB. It saturates at all-ones and holds in HALTED.
- A start pulse in RUN/DRAIN is ignored.
- Reset mid-RUN aborts immediately; stores not yet in Mem are lost.

Test Plan:
- Debug round trip: in IDLE, setup_mem addr 600 data 0xDEADBEEF_01234567, then verify_mem addr 600 -> mem_data_out = 0xDEADBEEF_01234567 one cycle later; verify in RUN leaves mem_data_out unchanged.
- Load/store program:
  - Memory: mem[0]=LOAD r1,[r0+0]; mem[1]=STORE [r0+1],r1; mem[2]=HALT; mem[512]=0x55.
  - Start -> mem[513]=0x55, done=1, retired=2.
  - The STORE is held exactly 2 cycles in Decode (two bubbles observed in D/E).
- Independent sequence: 4 LOADs to r1..r4 from 512..515, then HALT -> no stall cycles.
  - done asserts 4 cycles after HALT is decoded, plus the pipeline drain of the last load; r1..r4 hold the loaded values; retired=4.
- EA wrap: LOAD r2,[r0+0x7FFF] with MEM_ADDR_W=10 -> reads address (512+32767) mod 1024 = 511.
- Restart: after HALTED, start again -> retired resets to 0 and the program re-executes identically.
- Async reset mid-RUN: assert reset=0 between clock edges while a LOAD is in Execute -> running=0, retired=0 and FSM=IDLE immediately, with no memory write.
